// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between the instruction-fetch (I) and data (D) ports.
// D has priority; I is served after STARVE_MAX consecutive D grants while it waits.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // tag_own_r: 1'b1 marks a read issued by the D port
  logic [LAT-1:0] tag_vld_r;
  logic [LAT-1:0] tag_own_r;
  logic [3:0]     starve_cnt_r;
  logic [3:0]     starve_cnt_s;
  logic           i_win_s;
  logic           d_win_s;
  logic           pop_s;
  logic           pop_own_s;

  // Per-cycle winner selection; nothing wins while reset is asserted
  always_comb begin
    i_win_s = 1'b0;
    d_win_s = 1'b0;
    if (!rst_n) begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end else if (i_req && d_req) begin
      if (starve_cnt_r == STARVE_LIM) begin
        i_win_s = 1'b1;
      end else begin
        d_win_s = 1'b1;
      end
    end else if (i_req) begin
      i_win_s = 1'b1;
    end else if (d_req) begin
      d_win_s = 1'b1;
    end else begin
      i_win_s = 1'b0;
      d_win_s = 1'b0;
    end
  end

  // Memory command mux and return-data routing from the final tag stage
  always_comb begin
    i_gnt     = i_win_s;
    d_gnt     = d_win_s;
    m_req     = i_win_s | d_win_s;
    m_we      = d_win_s & d_we;
    m_addr    = {AW{1'b0}};
    if (d_win_s) begin
      m_addr = d_addr;
    end else if (i_win_s) begin
      m_addr = i_addr;
    end else begin
      m_addr = {AW{1'b0}};
    end
    if (rst_n) begin
      m_wdata = d_wdata;
    end else begin
      m_wdata = {DW{1'b0}};
    end
    pop_s     = tag_vld_r[LAT-1];
    pop_own_s = tag_own_r[LAT-1];
    i_rvalid  = pop_s & ~pop_own_s;
    d_rvalid  = pop_s & pop_own_s;
    if (i_rvalid) begin
      i_rdata = m_rdata;
    end else begin
      i_rdata = {DW{1'b0}};
    end
    if (d_rvalid) begin
      d_rdata = m_rdata;
    end else begin
      d_rdata = {DW{1'b0}};
    end
    busy = rst_n & (i_req | d_req | (|tag_vld_r));
  end

  // Starvation counter: counts D wins over a waiting I, saturating at the limit
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (i_win_s || !i_req) begin
      starve_cnt_s = 4'd0;
    end else if (d_win_s && (starve_cnt_r < STARVE_LIM)) begin
      starve_cnt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // State registers: starvation count and read-tag shift pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
      tag_vld_r    <= {LAT{1'b0}};
      tag_own_r    <= {LAT{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_s;
      tag_vld_r[0] <= i_win_s | (d_win_s & ~d_we);
      tag_own_r[0] <= d_win_s;
      for (int k = 1; k < LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_own_r[k] <= tag_own_r[k-1];
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT=1,2,3) share stimulus,
// each with its own latency-matched memory model.
module tb_mem_port_arbiter;

  localparam logic [31:0] IA = 32'h0000_0020;
  localparam logic [31:0] DA = 32'h0000_0030;
  localparam logic [31:0] PI = 32'h2002_0009;
  localparam logic [31:0] PD = 32'h2002_000D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;

  logic        i_gnt_v [1:3];
  logic        i_rvalid_v [1:3];
  logic [31:0] i_rdata_v [1:3];
  logic        d_gnt_v [1:3];
  logic        d_rvalid_v [1:3];
  logic [31:0] d_rdata_v [1:3];
  logic        m_req_v [1:3];
  logic        m_we_v [1:3];
  logic [31:0] m_addr_v [1:3];
  logic [31:0] m_wdata_v [1:3];
  logic [31:0] m_rdata_v [1:3];
  logic        busy_v [1:3];

  int checks = 0;
  int errors = 0;

  logic        wr_vld = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'h2002_0000 + {2'b00, a[31:2]} + 32'd1;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wr_vld && (a == wr_addr)) return wr_data;
    return pat(a);
  endfunction

  for (genvar g = 1; g <= 3; g++) begin : g_dut
    logic [31:0] pipe [0:3];

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(g), .STARVE_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt_v[g]),
      .i_rvalid(i_rvalid_v[g]), .i_rdata(i_rdata_v[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_v[g]), .d_rvalid(d_rvalid_v[g]), .d_rdata(d_rdata_v[g]),
      .m_req(m_req_v[g]), .m_we(m_we_v[g]), .m_addr(m_addr_v[g]),
      .m_wdata(m_wdata_v[g]), .m_rdata(m_rdata_v[g]), .busy(busy_v[g])
    );

    always @(posedge clk) begin
      pipe[0] <= (m_req_v[g] && !m_we_v[g]) ? mem_rd(m_addr_v[g]) : 32'h0BAD_0BAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign m_rdata_v[g] = pipe[g-1];
  end

  // All instances see identical grants, so the LAT=1 instance drives memory writes
  always @(posedge clk) begin
    if (m_req_v[1] && m_we_v[1]) begin
      wr_vld  <= 1'b1;
      wr_addr <= m_addr_v[1];
      wr_data <= m_wdata_v[1];
    end
  end

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dwd;
    logic eig; logic edg; logic emw; logic [31:0] ema;
    logic eirv; logic [31:0] eird;
    logic edrv; logic [31:0] edrd;
    logic eb;
  } vec_t;

  vec_t tbl [0:27];

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] dwd,
                              input logic eig, input logic edg, input logic emw, input logic [31:0] ema,
                              input logic eirv, input logic [31:0] eird,
                              input logic edrv, input logic [31:0] edrd, input logic eb);
    vec_t r;
    r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dwd = dwd;
    r.eig = eig; r.edg = edg; r.emw = emw; r.ema = ema;
    r.eirv = eirv; r.eird = eird; r.edrv = edrv; r.edrd = edrd; r.eb = eb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input int g, input string tag,
                         input logic eig, input logic edg, input logic emw,
                         input logic [31:0] ema, input logic [31:0] emwd,
                         input logic eirv, input logic [31:0] eird,
                         input logic edrv, input logic [31:0] edrd, input logic eb);
    chk({tag, " i_gnt"},    32'(i_gnt_v[g]),    32'(eig));
    chk({tag, " d_gnt"},    32'(d_gnt_v[g]),    32'(edg));
    chk({tag, " m_req"},    32'(m_req_v[g]),    32'(eig | edg));
    chk({tag, " m_we"},     32'(m_we_v[g]),     32'(emw));
    chk({tag, " m_addr"},   m_addr_v[g],        ema);
    chk({tag, " m_wdata"},  m_wdata_v[g],       emwd);
    chk({tag, " i_rvalid"}, 32'(i_rvalid_v[g]), 32'(eirv));
    chk({tag, " i_rdata"},  i_rdata_v[g],       eird);
    chk({tag, " d_rvalid"}, 32'(d_rvalid_v[g]), 32'(edrv));
    chk({tag, " d_rdata"},  d_rdata_v[g],       edrd);
    chk({tag, " busy"},     32'(busy_v[g]),     32'(eb));
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  initial begin
    // LAT=1 vectors: single I read, starvation rotation, i_req drop, write then read
    tbl[0]  = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     0, 0,  0, 0,  0);
    tbl[1]  = mk(1, 32'h10,0, 0, 0,     0,            1, 0, 0, 32'h10,0, 0,  0, 0,  1);
    tbl[2]  = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     1, 32'h2002_0005, 0, 0, 1);
    tbl[3]  = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     0, 0,  0, 0,  0);
    tbl[4]  = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  0, 0,  1);
    tbl[5]  = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[6]  = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[7]  = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[8]  = mk(1, IA,    1, 0, DA,    0,            1, 0, 0, IA,    0, 0,  1, PD, 1);
    tbl[9]  = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    1, PI, 0, 0,  1);
    tbl[10] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[11] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[12] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[13] = mk(1, IA,    1, 0, DA,    0,            1, 0, 0, IA,    0, 0,  1, PD, 1);
    tbl[14] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    1, PI, 0, 0,  1);
    tbl[15] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[16] = mk(0, 0,     1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[17] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[18] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[19] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[20] = mk(1, IA,    1, 0, DA,    0,            0, 1, 0, DA,    0, 0,  1, PD, 1);
    tbl[21] = mk(1, IA,    1, 0, DA,    0,            1, 0, 0, IA,    0, 0,  1, PD, 1);
    tbl[22] = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     1, PI, 0, 0,  1);
    tbl[23] = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     0, 0,  0, 0,  0);
    tbl[24] = mk(0, 0,     1, 1, 32'h40,32'hDEAD_BEEF,0, 1, 1, 32'h40,0, 0,  0, 0,  1);
    tbl[25] = mk(0, 0,     1, 0, 32'h40,0,            0, 1, 0, 32'h40,0, 0,  0, 0,  1);
    tbl[26] = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     0, 0,  1, 32'hDEAD_BEEF, 1);
    tbl[27] = mk(0, 0,     0, 0, 0,     0,            0, 0, 0, 0,     0, 0,  0, 0,  0);

    // Reset with both ports requesting: every output must read zero
    drive(1, 32'h10, 1, 0, DA, 32'h5555_AAAA);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 1; g <= 3; g++)
      chk_all(g, $sformatf("rst%0d", g), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].ir, tbl[i].ia, tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dwd);
      @(negedge clk);
      chk_all(1, $sformatf("v%0d", i), tbl[i].eig, tbl[i].edg, tbl[i].emw, tbl[i].ema, tbl[i].dwd,
              tbl[i].eirv, tbl[i].eird, tbl[i].edrv, tbl[i].edrd, tbl[i].eb);
    end
    repeat (3) @(posedge clk);

    // LAT=3: alternating I/D reads for 6 cycles, returns 3 cycles later
    for (int c = 0; c < 10; c++) begin
      logic eig, edg, eirv, edrv;
      logic [31:0] ema, eird, edrd;
      int r;
      @(posedge clk); #1;
      eig = 1'b0; edg = 1'b0; ema = 32'd0;
      if (c < 6 && (c % 2) == 0) begin
        ema = 32'h80 + 32'(4 * c);
        drive(1, ema, 0, 0, 0, 0);
        eig = 1'b1;
      end else if (c < 6) begin
        ema = 32'hC0 + 32'(4 * c);
        drive(0, 0, 1, 0, ema, 0);
        edg = 1'b1;
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      eirv = 1'b0; edrv = 1'b0; eird = 32'd0; edrd = 32'd0;
      r = c - 3;
      if (r >= 0 && r < 6) begin
        if ((r % 2) == 0) begin
          eirv = 1'b1; eird = pat(32'h80 + 32'(4 * r));
        end else begin
          edrv = 1'b1; edrd = pat(32'hC0 + 32'(4 * r));
        end
      end
      @(negedge clk);
      chk_all(3, $sformatf("lat3_c%0d", c), eig, edg, 0, ema, 0, eirv, eird, edrv, edrd, c <= 8);
    end
    repeat (2) @(posedge clk);

    // LAT=2: two D reads in flight (starve count at 2), then a one-cycle reset pulse
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive(1, 32'h10, 1, 0, DA, 0);
      @(negedge clk);
      chk_all(2, $sformatf("pre_c%0d", c), 0, 1, 0, DA, 0, 0, 0, 0, 0, 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1, 32'h10, 1, 0, DA, 32'h1234_5678);
    #1;
    chk_all(2, "rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_all(2, "rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, IA, 1, 0, DA, 0);
    for (int p = 0; p < 6; p++) begin
      @(negedge clk);
      chk_all(2, $sformatf("post_p%0d", p), p == 4, p != 4, 0, (p == 4) ? IA : DA, 0,
              0, 0, p >= 2, (p >= 2) ? PD : 32'd0, 1);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
